vec_reduce_acc: RTL

- Pipelined reducer directly downstream of the vector-vector op stage.
- Takes each result vector, sums its VEC_LEN lanes through a registered adder tree, then accumulates the tree sums over a multi-beat group.
- A group is delimited by in_last. With multiply selected upstream, the output is a dot product.
- valid/ready handshake on both sides; one result beat per group.

---
 rtl/qwac_pkg.sv | 59 +++++
 rtl/vec_reduce_acc_tree_level.sv | 51 +++++
 rtl/vec_reduce_acc.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/qwac_pkg.sv
// Shared constants, lane/accumulator types and overflow-aware adders for the vector reducer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a. Saturating adder variant is selected by VEC_REDUCE_ACC_SATURATE_EN in vec_reduce_acc.
package qwac_pkg;

    localparam int BITS     = 8;
    localparam int VEC_LEN  = 4;
    localparam int ACC_BITS = 2 * BITS;

    // Adders work on a 64-bit signed carrier so one function serves any
    // accumulator width up to 62 bits; the exact sum never overflows the carrier.
    localparam int WIDE = 64;

    typedef logic signed [BITS-1:0]     lane_t;
    typedef logic signed [ACC_BITS-1:0] acc_t;

    typedef struct packed {
        logic signed [WIDE-1:0] sum;
        logic                   ovf;
    } add_res_t;

    function automatic logic signed [WIDE-1:0] acc_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [WIDE-1:0] acc_min(input int w);
        return -acc_max(w) - 64'sd1;
    endfunction

    // Two's-complement add at width w: sum wraps, ovf flags a signed overflow.
    function automatic add_res_t add_ovf(input logic signed [WIDE-1:0] a,
                                         input logic signed [WIDE-1:0] b,
                                         input int                     w);
        add_res_t               r;
        logic signed [WIDE-1:0] s;
        s     = a + b;
        r.ovf = (s > acc_max(w)) || (s < acc_min(w));
        // Keep the low w bits and sign-extend them back over the carrier.
        r.sum = (s <<< (WIDE - w)) >>> (WIDE - w);
        return r;
    endfunction

    // Same as add_ovf but the sum clamps to the representable range.
    function automatic add_res_t add_ovf_sat(input logic signed [WIDE-1:0] a,
                                             input logic signed [WIDE-1:0] b,
                                             input int                     w);
        add_res_t               r;
        logic signed [WIDE-1:0] s;
        r = add_ovf(a, b, w);
        s = a + b;
        if (s > acc_max(w)) begin
            r.sum = acc_max(w);
        end else if (s < acc_min(w)) begin
            r.sum = acc_min(w);
        end
        return r;
    endfunction

endpackage

// File: rtl/vec_reduce_acc_tree_level.sv
// One registered adder-tree level: N input words -> N/2 pairwise sums, valid/last ride alongside.
// Latency: 1 cycle.
// Backpressure: hold_i freezes data, valid and last in place.
// Ports: clock/reset, hold_i, in_vld_i/in_last_i/in_dat_i (N words), out_vld_o/out_last_o/out_dat_o (N/2 words).
module reduce_tree_level
    import qwac_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               hold_i,
    input  logic               in_vld_i,
    input  logic               in_last_i,
    input  logic [N*W-1:0]     in_dat_i,
    output logic               out_vld_o,
    output logic               out_last_o,
    output logic [(N/2)*W-1:0] out_dat_o
);

    logic [(N/2)*W-1:0] sum_d;
    logic [(N/2)*W-1:0] dat_q;
    logic               vld_q;
    logic               last_q;

    // Inputs are already sign-extended to W, so plain W-bit adds are exact.
    always_comb begin
        sum_d = '0;
        for (int j = 0; j < N / 2; j++) begin
            sum_d[j*W +: W] = in_dat_i[(2*j)*W +: W] + in_dat_i[(2*j+1)*W +: W];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_q  <= 1'b0;
            last_q <= 1'b0;
            dat_q  <= '0;
        end else if (!hold_i) begin
            vld_q  <= in_vld_i;
            last_q <= in_last_i;
            dat_q  <= sum_d;
        end
    end

    assign out_vld_o  = vld_q;
    assign out_last_o = last_q;
    assign out_dat_o  = dat_q;

endmodule

// File: rtl/vec_reduce_acc.sv
// Sums VEC_LEN signed lanes per beat through a registered tree, accumulates tree sums over an in_last-delimited group.
// Latency: L+1 register stages (L = log2(VEC_LEN) tree levels + accumulate) from beat presented to out_valid; 1 beat/cycle.
// Backpressure: out_valid && !out_ready stalls the whole pipeline and drops in_ready.
// Option: define VEC_REDUCE_ACC_SATURATE_EN to clamp the accumulate add instead of wrapping.
// Ports: clock, reset (async active-low), in_valid/in_ready/in_vec/in_last, out_valid/out_ready/out_sum/out_count/out_ovf.
module vec_reduce_acc
    import qwac_pkg::*;
#(
    parameter int IN_BITS  = qwac_pkg::BITS,
    parameter int VEC_LEN  = qwac_pkg::VEC_LEN,
    parameter int ACC_BITS = 2 * IN_BITS,
    parameter int CNT_BITS = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [VEC_LEN*IN_BITS-1:0] in_vec,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ACC_BITS-1:0]        out_sum,
    output logic [CNT_BITS-1:0]        out_count,
    output logic                       out_ovf
);

    localparam int L     = $clog2(VEC_LEN);
    // Every tree node (leaves plus all level outputs) lives in one flat vector:
    // level k reads from offset 2V-2(V>>k) and writes at offset 2V-(V>>k).
    localparam int NODES = 2 * VEC_LEN - 1;

    logic                     stall;
    logic [NODES*ACC_BITS-1:0] node_dat;
    logic [L:0]               lvl_vld;
    logic [L:0]               lvl_last;

    logic signed [ACC_BITS-1:0] tree_sum;
    logic                       tree_vld;
    logic                       tree_last;

    logic signed [ACC_BITS-1:0] acc_q;
    logic [CNT_BITS-1:0]        cnt_q;
    logic                       ovf_q;
    logic                       out_valid_q;
    logic [ACC_BITS-1:0]        out_sum_q;
    logic [CNT_BITS-1:0]        out_count_q;
    logic                       out_ovf_q;

    add_res_t                   add_r;
    logic signed [ACC_BITS-1:0] sum_d;
    logic [CNT_BITS-1:0]        cnt_inc;

    assign stall    = out_valid_q && !out_ready;
    assign in_ready = !stall;

    // Leaves: sign-extend every lane to the accumulator width.
    for (genvar i = 0; i < VEC_LEN; i++) begin : g_leaf
        assign node_dat[i*ACC_BITS +: ACC_BITS] =
            {{(ACC_BITS-IN_BITS){in_vec[i*IN_BITS+IN_BITS-1]}}, in_vec[i*IN_BITS +: IN_BITS]};
    end

    assign lvl_vld[0]  = in_valid && !stall;
    assign lvl_last[0] = in_last;

    for (genvar k = 0; k < L; k++) begin : g_lvl
        localparam int N       = VEC_LEN >> k;
        localparam int IN_OFF  = 2 * VEC_LEN - 2 * N;
        localparam int OUT_OFF = 2 * VEC_LEN - N;

        reduce_tree_level #(
            .N (N),
            .W (ACC_BITS)
        ) u_level (
            .clock      (clock),
            .reset      (reset),
            .hold_i     (stall),
            .in_vld_i   (lvl_vld[k]),
            .in_last_i  (lvl_last[k]),
            .in_dat_i   (node_dat[IN_OFF*ACC_BITS +: N*ACC_BITS]),
            .out_vld_o  (lvl_vld[k+1]),
            .out_last_o (lvl_last[k+1]),
            .out_dat_o  (node_dat[OUT_OFF*ACC_BITS +: (N/2)*ACC_BITS])
        );
    end

    assign tree_sum  = node_dat[(NODES-1)*ACC_BITS +: ACC_BITS];
    assign tree_vld  = lvl_vld[L];
    assign tree_last = lvl_last[L];

    always_comb begin
`ifdef VEC_REDUCE_ACC_SATURATE_EN
        add_r = add_ovf_sat({{(WIDE-ACC_BITS){acc_q[ACC_BITS-1]}}, acc_q},
                            {{(WIDE-ACC_BITS){tree_sum[ACC_BITS-1]}}, tree_sum},
                            ACC_BITS);
`else
        add_r = add_ovf({{(WIDE-ACC_BITS){acc_q[ACC_BITS-1]}}, acc_q},
                        {{(WIDE-ACC_BITS){tree_sum[ACC_BITS-1]}}, tree_sum},
                        ACC_BITS);
`endif
        sum_d   = add_r.sum[ACC_BITS-1:0];
        // Beat counter sticks at all-ones rather than wrapping.
        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_BITS'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else if (!stall) begin
            if (tree_vld && tree_last) begin
                // Closing beat: publish the group and restart the accumulator.
                // Overwrites any result being handed off this same cycle.
                out_valid_q <= 1'b1;
                out_sum_q   <= sum_d;
                out_count_q <= cnt_inc;
                out_ovf_q   <= ovf_q | add_r.ovf;
                acc_q       <= '0;
                cnt_q       <= '0;
                ovf_q       <= 1'b0;
            end else begin
                // Not stalled means any held result was taken this cycle.
                out_valid_q <= 1'b0;
                if (tree_vld) begin
                    acc_q <= sum_d;
                    cnt_q <= cnt_inc;
                    ovf_q <= ovf_q | add_r.ovf;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule
